// File: rtl/rally_score_ctrl.sv
// rally_score_ctrl
//
// Purpose:
//   Rally and score controller downstream of the physics/render block. Watches the
//   ball position once per physics frame, detects a floor landing, awards the point
//   to the player on the far side of the net, holds the physics engine during the
//   post-point pause, requests a re-serve and declares the winner at the target score.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high reset
//   frame_tick    one-cycle pulse per physics update, qualifies ball_x/ball_y
//   ball_x        ball centre x, pixels
//   ball_y        ball centre y, pixels (down is positive)
//   start         begin a game, or a new game after game over
//   play_en       physics engine may advance (high only in PLAY)
//   serve_req     one-cycle pulse: physics reloads serve positions for serve_side
//   serve_side    0 = left player serves, 1 = right player serves
//   score_left    left player score
//   score_right   right player score
//   winner_valid  high while in game over
//   winner        0 = left won, 1 = right won (valid with winner_valid)
//   state_o       current state encoding for LEDs/debug

module rally_score_ctrl #(
    parameter int unsigned FLOOR_Y      = 413,
    parameter int unsigned NET_X        = 320,
    parameter int unsigned WIN_SCORE    = 15,
    parameter int unsigned PAUSE_FRAMES = 60,
    parameter int unsigned SCORE_W      = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic [9:0]         ball_x,
    input  logic [9:0]         ball_y,
    input  logic               start,
    output logic               play_en,
    output logic               serve_req,
    output logic               serve_side,
    output logic [SCORE_W-1:0] score_left,
    output logic [SCORE_W-1:0] score_right,
    output logic               winner_valid,
    output logic               winner,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        StWaitStart = 3'd0,
        StServe     = 3'd1,
        StPlay      = 3'd2,
        StPause     = 3'd3,
        StGameOver  = 3'd4
    } state_e;

    localparam int unsigned CntW = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;

    localparam logic [CntW-1:0]    CntLast  = CntW'(PAUSE_FRAMES - 1);
    localparam logic [CntW-1:0]    CntOne   = CntW'(1);
    localparam logic [9:0]         FloorY   = 10'(FLOOR_Y);
    localparam logic [9:0]         NetX     = 10'(NET_X);
    localparam logic [SCORE_W-1:0] WinScore = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] ScoreOne = SCORE_W'(1);

    state_e              state_q, state_d;
    logic [SCORE_W-1:0]  score_l_q, score_l_d;
    logic [SCORE_W-1:0]  score_r_q, score_r_d;
    logic                side_q, side_d;
    logic                winner_q, winner_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                play_en_q;
    logic                serve_req_q;
    logic                winner_valid_q;

    logic                landing;
    logic                scorer;     // 1 = right player takes the point
    logic [SCORE_W-1:0]  score_l_inc;
    logic [SCORE_W-1:0]  score_r_inc;

    assign landing     = frame_tick && (ball_y >= FloorY);
    // Ball on the left half means the left player lost the rally.
    assign scorer      = (ball_x < NetX);
    assign score_l_inc = score_l_q + ScoreOne;
    assign score_r_inc = score_r_q + ScoreOne;

    always_comb begin
        state_d   = state_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        side_d    = side_q;
        winner_d  = winner_q;
        cnt_d     = cnt_q;

        case (state_q)
            StWaitStart: begin
                if (start) begin
                    state_d = StServe;
                end
            end

            StServe: begin
                state_d = StPlay;
            end

            StPlay: begin
                if (landing) begin
                    side_d = scorer;
                    if (scorer) begin
                        score_r_d = score_r_inc;
                    end else begin
                        score_l_d = score_l_inc;
                    end
                    if ((scorer ? score_r_inc : score_l_inc) == WinScore) begin
                        winner_d = scorer;
                        state_d  = StGameOver;
                    end else begin
                        cnt_d   = '0;
                        state_d = StPause;
                    end
                end
            end

            StPause: begin
                if (frame_tick) begin
                    cnt_d = cnt_q + CntOne;
                    if (cnt_q == CntLast) begin
                        state_d = StServe;
                    end
                end
            end

            StGameOver: begin
                if (start) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    // Loser of the previous game serves first.
                    side_d    = ~winner_q;
                    state_d   = StServe;
                end
            end

            default: begin
                state_d = StWaitStart;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StWaitStart;
            score_l_q      <= '0;
            score_r_q      <= '0;
            side_q         <= 1'b1;
            winner_q       <= 1'b0;
            cnt_q          <= '0;
            play_en_q      <= 1'b0;
            serve_req_q    <= 1'b0;
            winner_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            score_l_q      <= score_l_d;
            score_r_q      <= score_r_d;
            side_q         <= side_d;
            winner_q       <= winner_d;
            cnt_q          <= cnt_d;
            // Decoded from the next state so they switch on the edge entering the state.
            play_en_q      <= (state_d == StPlay);
            serve_req_q    <= (state_d == StServe);
            winner_valid_q <= (state_d == StGameOver);
        end
    end

    assign play_en      = play_en_q;
    assign serve_req    = serve_req_q;
    assign serve_side   = side_q;
    assign score_left   = score_l_q;
    assign score_right  = score_r_q;
    assign winner_valid = winner_valid_q;
    assign winner       = winner_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_rally_score_ctrl.sv
// Self-checking bench for rally_score_ctrl: directed scenarios with literal
// expectations, then randomized play compared every cycle against a rule-level model.

module tb_rally_score_ctrl;

    localparam int FloorY = 413;
    localparam int NetX   = 320;
    localparam int WinSc  = 15;
    localparam int PauseF = 60;

    logic       clk;
    logic       reset;
    logic       ft;
    logic [9:0] bx;
    logic [9:0] by;
    logic       st;

    logic       play_en;
    logic       serve_req;
    logic       serve_side;
    logic [4:0] score_left;
    logic [4:0] score_right;
    logic       winner_valid;
    logic       winner;
    logic [2:0] state_o;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    rally_score_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (ft),
        .ball_x      (bx),
        .ball_y      (by),
        .start       (st),
        .play_en     (play_en),
        .serve_req   (serve_req),
        .serve_side  (serve_side),
        .score_left  (score_left),
        .score_right (score_right),
        .winner_valid(winner_valid),
        .winner      (winner),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rule-level model: phase of the game, both scores, who serves, who won,
    // and how many frame ticks have elapsed since the last point.
    int m_phase;   // 0 wait, 1 serve, 2 play, 3 pause, 4 game over
    int m_left;
    int m_right;
    int m_side;
    int m_win;
    int m_ticks;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0;
            m_left  <= 0;
            m_right <= 0;
            m_side  <= 1;
            m_win   <= 0;
            m_ticks <= 0;
        end else begin
            if (m_phase == 0) begin
                if (st) m_phase <= 1;
            end else if (m_phase == 1) begin
                m_phase <= 2;
            end else if (m_phase == 2) begin
                if (ft && int'(by) >= FloorY) begin
                    if (int'(bx) < NetX) begin
                        m_right <= m_right + 1;
                        m_side  <= 1;
                        if (m_right + 1 == WinSc) begin
                            m_win   <= 1;
                            m_phase <= 4;
                        end else begin
                            m_ticks <= 0;
                            m_phase <= 3;
                        end
                    end else begin
                        m_left <= m_left + 1;
                        m_side <= 0;
                        if (m_left + 1 == WinSc) begin
                            m_win   <= 0;
                            m_phase <= 4;
                        end else begin
                            m_ticks <= 0;
                            m_phase <= 3;
                        end
                    end
                end
            end else if (m_phase == 3) begin
                if (ft) begin
                    m_ticks <= m_ticks + 1;
                    if (m_ticks + 1 == PauseF) m_phase <= 1;
                end
            end else begin
                if (st) begin
                    m_left  <= 0;
                    m_right <= 0;
                    m_side  <= 1 - m_win;
                    m_phase <= 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            chk("state_o", int'(state_o), m_phase);
            chk("play_en", int'(play_en), int'(m_phase == 2));
            chk("serve_req", int'(serve_req), int'(m_phase == 1));
            chk("winner_valid", int'(winner_valid), int'(m_phase == 4));
            chk("score_left", int'(score_left), m_left);
            chk("score_right", int'(score_right), m_right);
            chk("serve_side", int'(serve_side), m_side);
            if (m_phase == 4) chk("winner", int'(winner), m_win);
        end
    end

    task automatic step(input logic f, input logic [9:0] x, input logic [9:0] y,
                        input logic s);
        @(negedge clk);
        ft = f;
        bx = x;
        by = y;
        st = s;
        @(posedge clk);
        #1;
        ft = 1'b0;
        st = 1'b0;
    endtask

    task automatic pause_out();
        repeat (PauseF) step(1'b1, 10'd0, 10'd0, 1'b0);
        step(1'b0, 10'd0, 10'd0, 1'b0);
    endtask

    task automatic point(input logic [9:0] x);
        step(1'b1, x, 10'd420, 1'b0);
        pause_out();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, int'(state_o), 0);
        chk({tag, "_play_en"}, int'(play_en), 0);
        chk({tag, "_serve_req"}, int'(serve_req), 0);
        chk({tag, "_serve_side"}, int'(serve_side), 1);
        chk({tag, "_score_l"}, int'(score_left), 0);
        chk({tag, "_score_r"}, int'(score_right), 0);
        chk({tag, "_winner_valid"}, int'(winner_valid), 0);
        chk({tag, "_winner"}, int'(winner), 0);
    endtask

    initial begin
        reset = 1'b1;
        ft    = 1'b0;
        st    = 1'b0;
        bx    = '0;
        by    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset  = 1'b0;
        cmp_en = 1'b1;
        #1;
        chk_reset_vals("rst");

        // Frame ticks before the game starts are ignored.
        step(1'b1, 10'd100, 10'd413, 1'b0);
        chk("wait_tick_state", int'(state_o), 0);
        chk("wait_tick_score", int'(score_right), 0);

        step(1'b0, 10'd0, 10'd0, 1'b1);
        chk("serve_state", int'(state_o), 1);
        chk("serve_req_hi", int'(serve_req), 1);
        chk("serve_side_1", int'(serve_side), 1);
        chk("serve_play_lo", int'(play_en), 0);
        step(1'b0, 10'd0, 10'd0, 1'b0);
        chk("serve_req_lo", int'(serve_req), 0);
        chk("play_en_hi", int'(play_en), 1);

        step(1'b0, 10'd0, 10'd0, 1'b1);
        chk("play_start_ign", int'(state_o), 2);
        step(1'b1, 10'd320, 10'd412, 1'b0);
        chk("no_land_state", int'(state_o), 2);
        chk("no_land_score", int'(score_left), 0);

        step(1'b1, 10'd100, 10'd413, 1'b0);
        chk("land_l_score_r", int'(score_right), 1);
        chk("land_l_score_l", int'(score_left), 0);
        chk("land_l_side", int'(serve_side), 1);
        chk("land_l_play_en", int'(play_en), 0);
        chk("land_l_state", int'(state_o), 3);

        // Pause tick 1 is a repeated landing: no extra point.
        step(1'b1, 10'd100, 10'd413, 1'b0);
        chk("pause_reland", int'(score_right), 1);
        step(1'b0, 10'd0, 10'd0, 1'b1);
        chk("pause_start_ign", int'(state_o), 3);
        repeat (PauseF - 2) step(1'b1, 10'd0, 10'd0, 1'b0);
        chk("pause_59_state", int'(state_o), 3);
        chk("pause_59_req", int'(serve_req), 0);
        step(1'b1, 10'd0, 10'd0, 1'b0);
        chk("pause_60_state", int'(state_o), 1);
        chk("pause_60_req", int'(serve_req), 1);
        step(1'b0, 10'd0, 10'd0, 1'b0);

        step(1'b1, 10'd320, 10'd420, 1'b0);
        chk("net_score_l", int'(score_left), 1);
        chk("net_side", int'(serve_side), 0);
        pause_out();

        repeat (13) point(10'd500);
        chk("pre_win_score_l", int'(score_left), 14);
        step(1'b1, 10'd500, 10'd420, 1'b0);
        chk("win_score_l", int'(score_left), 15);
        chk("win_valid", int'(winner_valid), 1);
        chk("win_who", int'(winner), 0);
        chk("win_state", int'(state_o), 4);
        chk("win_play_en", int'(play_en), 0);
        step(1'b1, 10'd100, 10'd420, 1'b0);
        chk("over_hold_r", int'(score_right), 1);
        chk("over_hold_l", int'(score_left), 15);

        step(1'b0, 10'd0, 10'd0, 1'b1);
        chk("restart_score_l", int'(score_left), 0);
        chk("restart_score_r", int'(score_right), 0);
        chk("restart_side", int'(serve_side), 1);
        chk("restart_req", int'(serve_req), 1);
        chk("restart_valid", int'(winner_valid), 0);
        step(1'b0, 10'd0, 10'd0, 1'b0);

        point(10'd500);
        point(10'd500);
        point(10'd100);
        point(10'd100);
        step(1'b1, 10'd500, 10'd420, 1'b0);
        repeat (30) step(1'b1, 10'd0, 10'd0, 1'b0);
        chk("mid_pause_l", int'(score_left), 3);
        chk("mid_pause_r", int'(score_right), 2);
        chk("mid_pause_state", int'(state_o), 3);

        // Reset between clock edges must act without waiting for an edge.
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_vals("async");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 20000; i++) begin
            logic       f;
            logic       s;
            logic [9:0] x;
            logic [9:0] y;
            s = ($urandom_range(99) < 2);
            f = ($urandom_range(1) == 1);
            if ($urandom_range(7) == 0) x = 10'(318 + $urandom_range(4));
            else x = 10'($urandom_range(639));
            if ($urandom_range(3) == 0) y = 10'($urandom_range(412));
            else y = 10'(400 + $urandom_range(30));
            step(f, x, y, s);
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
